// File: rtl/dm_ctl.sv
// Debug Module controller: DMI register file, halt/resume requests and abstract command sequencing.
// DMI accesses ack one cycle after request; no backpressure, the transport never overlaps requests.
module dm_ctl #(
    parameter int TIMEOUT = 1024,
    parameter int VERSION = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmi_req,
    input  logic        dmi_write,
    input  logic [6:0]  dmi_addr,
    input  logic [31:0] dmi_wdata,
    output logic [31:0] dmi_rdata,
    output logic        dmi_ack,
    output logic        dbg_halt_req,
    output logic        dbg_resume_req,
    output logic [31:0] dbg_command,
    output logic        dbg_exec,
    output logic [31:0] dbg_data0,
    input  logic        dbg_halted,
    input  logic        dbg_done,
    input  logic        dbg_write,
    input  logic [31:0] dbg_wdata,
    input  logic        dbg_error,
    input  logic        dbg_exception
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BUSY      = 3'd1;
    localparam logic [2:0] ERR_NOT_SUPP  = 3'd2;
    localparam logic [2:0] ERR_EXCEPTION = 3'd3;
    localparam logic [2:0] ERR_HALT_RES  = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0] data0, data0_nxt;
    logic [31:0] command, command_nxt;
    logic [2:0]  cmderr, cmderr_nxt;
    logic        dmactive, dmactive_nxt;
    logic        haltreq, haltreq_nxt;
    logic        resume_pend, resume_pend_nxt;
    logic        resumeack, resumeack_nxt;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_val;
    logic        busy;
    logic        wr;
    logic [7:0]  cmdtype;

    assign busy    = (state == EXEC);
    assign wr      = dmi_req && dmi_write;
    assign cmdtype = dmi_wdata[31:24];

    // Read mux reflects state as it stood before the access edge.
    always_comb begin
        rd_val = 32'h0;
        case (dmi_addr)
            ADDR_DATA0:      rd_val = data0;
            ADDR_DMCONTROL:  rd_val = {haltreq, 30'h0, dmactive};
            ADDR_DMSTATUS:   rd_val = {14'h0, resumeack, resumeack, 4'h0,
                                       !dbg_halted, !dbg_halted, dbg_halted, dbg_halted,
                                       1'b1, 3'h0, 4'(VERSION)};
            ADDR_ABSTRACTCS: rd_val = {3'h0, 5'd0, 11'h0, busy, 1'b0, cmderr, 4'h0, 4'd1};
            default:         rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        data0_nxt       = data0;
        command_nxt     = command;
        cmderr_nxt      = cmderr;
        dmactive_nxt    = dmactive;
        haltreq_nxt     = haltreq;
        resume_pend_nxt = resume_pend;
        resumeack_nxt   = resumeack;

        // Core-side completion is applied before any DMI write on the same edge.
        if (busy) begin
            if (dbg_done) begin
                if (dbg_write)
                    data0_nxt = dbg_wdata;
                if ((dbg_error || dbg_exception) && cmderr_nxt == ERR_NONE)
                    cmderr_nxt = ERR_EXCEPTION;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                if (cmderr_nxt == ERR_NONE)
                    cmderr_nxt = ERR_EXCEPTION;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        if (resume_pend && !dbg_halted) begin
            resume_pend_nxt = 1'b0;
            resumeack_nxt   = 1'b1;
        end

        if (wr) begin
            case (dmi_addr)
                ADDR_DATA0: begin
                    if (busy) begin
                        if (cmderr_nxt == ERR_NONE)
                            cmderr_nxt = ERR_BUSY;
                    end else begin
                        data0_nxt = dmi_wdata;
                    end
                end
                ADDR_DMCONTROL: begin
                    dmactive_nxt = dmi_wdata[0];
                    haltreq_nxt  = dmi_wdata[31];
                    if (dmi_wdata[31]) begin
                        resume_pend_nxt = 1'b0;
                    end else if (dmi_wdata[30] && !busy) begin
                        resume_pend_nxt = 1'b1;
                        resumeack_nxt   = 1'b0;
                    end
                end
                ADDR_ABSTRACTCS: begin
                    if (busy) begin
                        if (cmderr_nxt == ERR_NONE)
                            cmderr_nxt = ERR_BUSY;
                    end else begin
                        cmderr_nxt = cmderr_nxt & ~dmi_wdata[10:8];
                    end
                end
                ADDR_COMMAND: begin
                    if (cmderr_nxt != ERR_NONE) begin
                        cmderr_nxt = cmderr_nxt;
                    end else if (busy) begin
                        cmderr_nxt = ERR_BUSY;
                    end else if (!dbg_halted) begin
                        cmderr_nxt = ERR_HALT_RES;
                    end else if (cmdtype != 8'd0 && cmdtype != 8'd2) begin
                        cmderr_nxt = ERR_NOT_SUPP;
                    end else begin
                        command_nxt = dmi_wdata;
                        state_nxt   = EXEC;
                        cnt_nxt     = '0;
                    end
                end
                default: ;
            endcase
        end

        // An inactive DM holds everything but dmactive at reset values; this also aborts a command.
        if (!dmactive_nxt) begin
            state_nxt       = IDLE;
            cnt_nxt         = '0;
            data0_nxt       = 32'h0;
            command_nxt     = 32'h0;
            cmderr_nxt      = ERR_NONE;
            haltreq_nxt     = 1'b0;
            resume_pend_nxt = 1'b0;
            resumeack_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            data0       <= 32'h0;
            command     <= 32'h0;
            cmderr      <= ERR_NONE;
            dmactive    <= 1'b0;
            haltreq     <= 1'b0;
            resume_pend <= 1'b0;
            resumeack   <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            data0       <= data0_nxt;
            command     <= command_nxt;
            cmderr      <= cmderr_nxt;
            dmactive    <= dmactive_nxt;
            haltreq     <= haltreq_nxt;
            resume_pend <= resume_pend_nxt;
            resumeack   <= resumeack_nxt;
            ack_q       <= dmi_req;
            rdata_q     <= (dmi_req && !dmi_write) ? rd_val : 32'h0;
        end
    end

    assign dmi_ack        = ack_q;
    assign dmi_rdata      = rdata_q;
    assign dbg_halt_req   = haltreq && dmactive;
    assign dbg_resume_req = resume_pend;
    assign dbg_command    = command;
    assign dbg_exec       = busy;
    assign dbg_data0      = data0;

endmodule

// File: tb/tb_dm_ctl.sv
// Directed bench for dm_ctl: DMI register access, halt/resume and abstract command sequencing.
module tb_dm_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmi_req;
    logic        dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;
    logic        dmi_ack;
    logic        dbg_halt_req;
    logic        dbg_resume_req;
    logic [31:0] dbg_command;
    logic        dbg_exec;
    logic [31:0] dbg_data0;
    logic        dbg_halted;
    logic        dbg_done;
    logic        dbg_write;
    logic [31:0] dbg_wdata;
    logic        dbg_error;
    logic        dbg_exception;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_ctl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dmi_req        (dmi_req),
        .dmi_write      (dmi_write),
        .dmi_addr       (dmi_addr),
        .dmi_wdata      (dmi_wdata),
        .dmi_rdata      (dmi_rdata),
        .dmi_ack        (dmi_ack),
        .dbg_halt_req   (dbg_halt_req),
        .dbg_resume_req (dbg_resume_req),
        .dbg_command    (dbg_command),
        .dbg_exec       (dbg_exec),
        .dbg_data0      (dbg_data0),
        .dbg_halted     (dbg_halted),
        .dbg_done       (dbg_done),
        .dbg_write      (dbg_write),
        .dbg_wdata      (dbg_wdata),
        .dbg_error      (dbg_error),
        .dbg_exception  (dbg_exception)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
        dmi_req = 1'b1; dmi_write = 1'b1; dmi_addr = a; dmi_wdata = d;
        step();
        dmi_req = 1'b0; dmi_write = 1'b0;
    endtask

    task automatic dmi_rd(input logic [6:0] a, output logic [31:0] d, output logic ack);
        dmi_req = 1'b1; dmi_write = 1'b0; dmi_addr = a; dmi_wdata = 32'h0;
        step();
        dmi_req = 1'b0;
        d   = dmi_rdata;
        ack = dmi_ack;
    endtask

    task automatic pulse_done(input logic wr, input logic [31:0] wd);
        dbg_done = 1'b1; dbg_write = wr; dbg_wdata = wd;
        step();
        dbg_done = 1'b0; dbg_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack;
        int          n;

        rst_n = 1'b0; dmi_req = 1'b0; dmi_write = 1'b0; dmi_addr = '0; dmi_wdata = '0;
        dbg_halted = 1'b0; dbg_done = 1'b0; dbg_write = 1'b0; dbg_wdata = '0;
        dbg_error = 1'b0; dbg_exception = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        check("rst_outputs", {dmi_ack, dbg_halt_req, dbg_resume_req, dbg_exec}, 32'h0);
        check("rst_rdata", dmi_rdata, 32'h0);
        check("rst_cmd_data0", dbg_command | dbg_data0, 32'h0);

        dmi_rd(7'h11, rd, ack);
        check("dmstatus_reset", rd, 32'h0000_0C82);
        check("ack_pulse", {31'h0, ack}, 32'h1);
        step();
        check("ack_drops", {31'h0, dmi_ack}, 32'h0);
        dmi_rd(7'h16, rd, ack);
        check("abstractcs_reset", rd, 32'h0000_0001);

        // Halt request
        dmi_wr(7'h10, 32'h8000_0001);
        check("halt_req", {31'h0, dbg_halt_req}, 32'h1);
        dbg_halted = 1'b1;
        step();
        dmi_rd(7'h11, rd, ack);
        check("dmstatus_halted", rd, 32'h0000_0382);
        dmi_rd(7'h10, rd, ack);
        check("dmcontrol_read", rd, 32'h8000_0001);

        // Good command, done after 5 cycles with write-back
        dmi_wr(7'h17, 32'h0022_1001);
        check("cmd_latched", dbg_command, 32'h0022_1001);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (dbg_exec) n++;
            if (i == 4) begin
                dbg_done = 1'b1; dbg_write = 1'b1; dbg_wdata = 32'hDEAD_BEEF;
            end
            step();
        end
        dbg_done = 1'b0; dbg_write = 1'b0;
        check("exec_cycles", n, 5);
        check("exec_low_after_done", {31'h0, dbg_exec}, 32'h0);
        dmi_rd(7'h04, rd, ack);
        check("data0_writeback", rd, 32'hDEAD_BEEF);
        check("dbg_data0", dbg_data0, 32'hDEAD_BEEF);
        dmi_rd(7'h16, rd, ack);
        check("cmderr_ok", rd, 32'h0000_0001);

        // Command while busy -> BUSY
        dmi_wr(7'h17, 32'h0022_1001);
        dmi_wr(7'h17, 32'h0022_1002);
        dmi_rd(7'h16, rd, ack);
        check("busy_cmderr1", rd, 32'h0000_1101);
        pulse_done(1'b0, 32'h0);
        check("exec_done2", {31'h0, dbg_exec}, 32'h0);
        dmi_wr(7'h17, 32'h0022_1003);
        step();
        check("cmd_ignored_exec", {31'h0, dbg_exec}, 32'h0);
        check("cmd_ignored_latch", dbg_command, 32'h0022_1001);
        dmi_wr(7'h16, 32'h0000_0700);
        dmi_rd(7'h16, rd, ack);
        check("w1c_clear", rd, 32'h0000_0001);
        dmi_rd(7'h04, rd, ack);
        check("data0_no_wb", rd, 32'hDEAD_BEEF);

        // Not halted -> HALT_RESUME; partial W1C
        dbg_halted = 1'b0;
        dmi_wr(7'h17, 32'h0022_1001);
        check("halt_res_noexec", {31'h0, dbg_exec}, 32'h0);
        dmi_rd(7'h16, rd, ack);
        check("cmderr4", rd, 32'h0000_0401);
        dmi_wr(7'h16, 32'h0000_0100);
        dmi_rd(7'h16, rd, ack);
        check("w1c_partial", rd, 32'h0000_0401);
        dmi_wr(7'h16, 32'h0000_0400);
        dbg_halted = 1'b1;

        // Unsupported cmdtype
        dmi_wr(7'h17, 32'h0100_0000);
        check("notsupp_noexec", {31'h0, dbg_exec}, 32'h0);
        dmi_rd(7'h16, rd, ack);
        check("cmderr2", rd, 32'h0000_0201);
        dmi_wr(7'h16, 32'h0000_0700);

        // Timeout on a memory-access command; late done ignored
        dmi_wr(7'h17, 32'h0200_0000);
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            if (dbg_exec) n++;
            step();
        end
        check("timeout_cycles", n, 1024);
        dmi_rd(7'h16, rd, ack);
        check("cmderr3_timeout", rd, 32'h0000_0301);
        pulse_done(1'b1, 32'h1234_5678);
        dmi_rd(7'h04, rd, ack);
        check("late_done_ignored", rd, 32'hDEAD_BEEF);
        dmi_wr(7'h16, 32'h0000_0700);

        // data0 write when idle; unmapped access
        dmi_wr(7'h04, 32'hCAFE_0001);
        dmi_wr(7'h05, 32'hFFFF_FFFF);
        dmi_rd(7'h04, rd, ack);
        check("data0_write", rd, 32'hCAFE_0001);
        dmi_rd(7'h05, rd, ack);
        check("unmapped_read", rd, 32'h0);
        dmi_rd(7'h17, rd, ack);
        check("command_reads0", rd, 32'h0);

        // Clearing dmactive aborts an in-flight command without cmderr
        dmi_wr(7'h17, 32'h0022_1001);
        check("exec_before_abort", {31'h0, dbg_exec}, 32'h1);
        dmi_wr(7'h10, 32'h0000_0000);
        check("abort_exec", {31'h0, dbg_exec}, 32'h0);
        check("abort_halt_req", {31'h0, dbg_halt_req}, 32'h0);
        dmi_rd(7'h16, rd, ack);
        check("abort_no_cmderr", rd, 32'h0000_0001);
        dmi_rd(7'h04, rd, ack);
        check("inactive_data0", rd, 32'h0);
        dmi_wr(7'h10, 32'h0000_0001);

        // Resume: core leaves halt 3 cycles after the request
        dmi_wr(7'h10, 32'h4000_0001);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (dbg_resume_req) n++;
            if (i == 2) dbg_halted = 1'b0;
            step();
        end
        check("resume_cycles", n, 3);
        dmi_rd(7'h11, rd, ack);
        check("dmstatus_resumed", rd, 32'h0003_0C82);
        dmi_rd(7'h10, rd, ack);
        check("resumereq_reads0", rd, 32'h0000_0001);

        // resumereq together with haltreq is ignored
        dbg_halted = 1'b1;
        dmi_wr(7'h10, 32'hC000_0001);
        check("resume_ignored", {30'h0, dbg_halt_req, dbg_resume_req}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_ctl.md
Name: dm_ctl

Overview:
- Debug Module side of the core debug handshake: the initiator that drives halt/resume requests and abstract commands toward the core's debug controller.
- Exposes a DMI-style register file (data0, dmcontrol, dmstatus, abstractcs, command) to the debug transport.
- Sequences each abstract command through exec/done, captures the core's write-back data, and reports completion status through cmderr.
- Sits between the DTM/DMI bridge and the core's debug interface.

Parameters:
- TIMEOUT, 1024: cycles allowed between exec assertion and dbg_done before the command is aborted.
- VERSION, 2: dmstatus.version value.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- dmi_req  input  1  single-cycle access request
- dmi_write  input  1  1 = write, 0 = read
- dmi_addr  input  7  DM register address
- dmi_wdata  input  32  write data
- dmi_rdata  output  32  read data, valid with dmi_ack
- dmi_ack  output  1  access complete
- dbg_halt_req  output  1  halt request to core
- dbg_resume_req  output  1  resume request to core
- dbg_command  output  32  latched abstract command
- dbg_exec  output  1  abstract command execute, held high while the command is in flight
- dbg_data0  output  32  data0 value presented to the core
- dbg_halted  input  1  core halted status
- dbg_done  input  1  abstract command finished, one-cycle pulse
- dbg_write  input  1  qualifies dbg_wdata on dbg_done
- dbg_wdata  input  32  core result for data0
- dbg_error  input  1  command failed, valid with dbg_done
- dbg_exception  input  1  core exception during command, valid with dbg_done

Behaviour:
- Reset (rst_n=0 at a clk edge): all registers 0; FSM IDLE; timeout counter 0. All outputs 0: dmi_ack, dmi_rdata, dbg_halt_req, dbg_resume_req, dbg_command, dbg_exec, dbg_data0.
- DMI handshake:
  - dmi_ack pulses exactly 1 cycle after dmi_req, with dmi_rdata registered in the same cycle.
  - Reads of unmapped addresses return 0; writes to unmapped addresses have no effect.
  - dmi_req is never issued while dmi_ack is pending.
- Register map:
  - 0x04 data0: R/W.
  - 0x10 dmcontrol: bit31 haltreq, bit30 resumereq (write-only, reads 0), bit0 dmactive.
  - 0x11 dmstatus: read-only.
  - 0x16 abstractcs: bit12 busy, [10:8] cmderr (W1C), [28:24] progbufsize=0, [3:0] datacount=1.
  - 0x17 command: write-only, reads 0.
- dmactive:
  - While dmactive=0, all DM state except dmactive itself is held in reset values.
  - A write clearing dmactive aborts any in-flight command: exec drops the next cycle, no cmderr.
  - Clearing dmactive wins over a simultaneous dbg_done.
- Halt/resume:
  - dbg_halt_req = haltreq && dmactive (level).
  - Writing resumereq=1 with haltreq=0 and busy=0 sets resume_pend and clears resumeack. Otherwise resumereq is ignored.
  - dbg_resume_req = resume_pend. Resume_pend clears on the first cycle dbg_halted=0, and resumeack is set on that same edge.
  - Writing haltreq=1 also clears resume_pend.
- dmstatus:
  - [17:16] allresumeack/anyresumeack = resumeack.
  - [11:10] allrunning/anyrunning = !dbg_halted.
  - [9:8] allhalted/anyhalted = dbg_halted.
  - bit7 authenticated = 1.
  - [3:0] = VERSION.
- Command write rules, checked in this order:
  - cmderr!=0: ignored.
  - busy: cmderr=1 (BUSY).
  - dbg_halted=0: cmderr=4 (HALT_RESUME).
  - cmdtype [31:24] not 0 (access register) or 2 (access memory): cmderr=2 (NOT_SUPPORTED).
  - Otherwise: latch dbg_command and go to EXEC.
- Writes to data0 or abstractcs while busy: cmderr=1 if cmderr==0. A data0 write is also dropped.
- FSM:
  - IDLE: busy=0, exec=0.
  - EXEC (entered 1 cycle after the command write): busy=1, exec=1, counter counts up from 0.
  - On dbg_done:
    - if dbg_write, data0 <= dbg_wdata;
    - if dbg_error or dbg_exception, cmderr=3 (EXCEPTION);
    - return to IDLE. Exec is low and busy is 0 on the following cycle.
  - On counter == TIMEOUT-1 without done: cmderr=3, go to IDLE. A late dbg_done is then ignored.
- cmderr is only ever set from 0; W1C clears only the written-1 bits.
- Simultaneous DMI write and dbg_done on the same edge: dbg_done updates take effect first. The DMI write is then judged against busy as it stood before that edge.

Test Plan:
- Reset, then read 0x11 -> 0x0000_0C82 (running, authenticated, version 2); read 0x16 -> 0x0000_0001.
- Write 0x10=0x8000_0001, core raises dbg_halted -> dbg_halt_req=1; read 0x11 shows bits 9:8 = 11b.
- While halted, write 0x17=0x0022_1001; core pulses dbg_done with dbg_write=1, dbg_wdata=0xDEAD_BEEF after 5 cycles -> exec high exactly 5 cycles; read 0x04 = 0xDEAD_BEEF; cmderr=0.
- Second command written while busy -> cmderr=1; further command ignored. Write 0x16=0x700 -> cmderr=0.
- Command with dbg_halted=0 -> cmderr=4, exec never asserts. Cmdtype 1 -> cmderr=2. No dbg_done for TIMEOUT cycles -> cmderr=3, exec drops.
- Write 0x10=0x4000_0001 while halted, core deasserts dbg_halted 3 cycles later -> resume_req high 3 cycles; read 0x11 bits 17:16 = 11b.
